// File: rtl/uno_pkg.sv
// Shared types and default widths for the uno PE sequencer slice.
package uno_pkg;

  localparam int UNO_MAC_BW = 12;
  localparam int UNO_RES_W  = 2 * UNO_MAC_BW + 4;

  typedef enum logic [1:0] {
    OP_MAC = 2'b00,
    OP_DIV = 2'b01,
    OP_EXP = 2'b10,
    OP_LOG = 2'b11
  } uno_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } seq_state_e;

  function automatic int res_width(input int bw);
    return 2 * bw + 4;
  endfunction

endpackage

// File: rtl/uno_coeff_rom.sv
// Polynomial coefficient table for the nonlinear ops, indexed by {op, idx}.
module uno_coeff_rom
  import uno_pkg::*;
#(
  parameter int MAC_BW = UNO_MAC_BW,
  parameter int IDX_W  = 2
) (
  input  uno_op_e            op,
  input  logic [IDX_W-1:0]   idx,
  output logic [MAC_BW-1:0]  coeff
);

  // Values are Q2.10 and come from the numerics team; terms past idx 3 are zero.
  logic signed [11:0] c12;

  always_comb begin
    c12 = '0;
    case (op)
      OP_DIV: begin
        case (int'(idx))
          0:       c12 = 12'sh400;
          1:       c12 = 12'shC00;
          2:       c12 = 12'sh400;
          3:       c12 = 12'shC00;
          default: c12 = '0;
        endcase
      end
      OP_EXP: begin
        case (int'(idx))
          0:       c12 = 12'sh400;
          1:       c12 = 12'sh400;
          2:       c12 = 12'sh200;
          3:       c12 = 12'sh0AB;
          default: c12 = '0;
        endcase
      end
      OP_LOG: begin
        case (int'(idx))
          0:       c12 = 12'sh000;
          1:       c12 = 12'sh400;
          2:       c12 = 12'shE00;
          3:       c12 = 12'sh155;
          default: c12 = '0;
        endcase
      end
      default: c12 = '0;
    endcase
    coeff = MAC_BW'(c12);
  end

endmodule

// File: rtl/uno_seq.sv
// Command sequencer for one uno PE: issues MAC streams or Horner sweeps,
// waits out the PE latency and hands the captured result back.
module uno_seq
  import uno_pkg::*;
#(
  parameter int MAC_BW     = UNO_MAC_BW,
  parameter int POLY_TERMS = 4,
  parameter int MAC_LAT    = 1,
  parameter int LEN_W      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [LEN_W-1:0]           cmd_len,
  input  logic [MAC_BW-1:0]          cmd_x,
  input  logic [MAC_BW-1:0]          cmd_y,
  input  logic [2*MAC_BW-1:0]        cmd_z,
  input  logic                       elem_valid,
  output logic                       elem_ready,
  input  logic [MAC_BW-1:0]          elem_x,
  input  logic [MAC_BW-1:0]          elem_y,
  output logic [1:0]                 pe_op,
  output logic [MAC_BW-1:0]          pe_x,
  output logic [MAC_BW-1:0]          pe_y,
  output logic [2*MAC_BW-1:0]        pe_z,
  output logic [MAC_BW-1:0]          pe_coeff,
  output logic                       pe_first,
  output logic                       pe_last,
  output logic                       pe_acc_en,
  input  logic [2*MAC_BW+3:0]        pe_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [2*MAC_BW+3:0]        res_data
);

  localparam int RES_W = res_width(MAC_BW);
  localparam int KW    = $clog2(POLY_TERMS);
  localparam int DW    = (MAC_LAT > 2) ? $clog2(MAC_LAT - 1) : 1;
  localparam logic [KW-1:0] K_LAST     = KW'(POLY_TERMS - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'((MAC_LAT >= 2) ? MAC_LAT - 2 : 0);
  localparam bit            SKIP_DRAIN = (MAC_LAT == 1);

  seq_state_e state, state_n;

  uno_op_e                    op_q;
  logic [LEN_W-1:0]           len_q;
  logic signed [MAC_BW-1:0]   x_q;
  logic signed [MAC_BW-1:0]   y_q;
  logic signed [2*MAC_BW-1:0] z_q;

  logic [LEN_W-1:0] cnt;
  logic [LEN_W:0]   cnt_inc;
  logic [KW-1:0]    k;
  logic [DW-1:0]    dcnt;
  logic             first_q;

  logic              is_mac, elem_fire, mac_end, nl_end, run_end, capture;
  logic [KW-1:0]     rom_idx;
  logic [MAC_BW-1:0] rom_coeff;

  assign is_mac     = (op_q == OP_MAC);
  assign elem_ready = (state == RUN) && is_mac && (cnt < len_q);
  assign elem_fire  = elem_valid && elem_ready;
  // One extra bit so len = 2^LEN_W-1 compares without wrapping.
  assign cnt_inc    = {1'b0, cnt} + {{LEN_W{1'b0}}, 1'b1};
  assign mac_end    = (len_q == '0) || (elem_fire && (cnt_inc == {1'b0, len_q}));
  assign nl_end     = (k == K_LAST);
  assign run_end    = is_mac ? mac_end : nl_end;
  assign capture    = ((state == RUN) && run_end && SKIP_DRAIN) ||
                      ((state == DRAIN) && (dcnt == DRAIN_LAST));
  assign rom_idx    = K_LAST - k;

  uno_coeff_rom #(
    .MAC_BW (MAC_BW),
    .IDX_W  (KW)
  ) u_rom (
    .op    (op_q),
    .idx   (rom_idx),
    .coeff (rom_coeff)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cmd_valid) state_n = RUN;
      RUN:     if (run_end) state_n = SKIP_DRAIN ? DONE : DRAIN;
      DRAIN:   if (dcnt == DRAIN_LAST) state_n = DONE;
      DONE:    if (res_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    res_valid = (state == DONE);
    pe_op     = '0;
    pe_x      = '0;
    pe_y      = '0;
    pe_z      = '0;
    pe_coeff  = '0;
    pe_first  = 1'b0;
    pe_last   = 1'b0;
    pe_acc_en = 1'b0;
    case (state)
      RUN: begin
        if (is_mac) begin
          // Stalls and len=0 feed zeros, so the PE accumulates +0 (or loads Z).
          pe_z      = z_q;
          pe_acc_en = !first_q;
          if (elem_fire) begin
            pe_x = elem_x;
            pe_y = elem_y;
          end
        end else begin
          pe_op    = op_q;
          pe_x     = x_q;
          pe_y     = y_q;
          pe_coeff = rom_coeff;
          pe_first = (k == '0);
          pe_last  = nl_end;
        end
      end
      DRAIN:   pe_op = op_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      k       <= '0;
      dcnt    <= '0;
      first_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt     <= '0;
          k       <= '0;
          dcnt    <= '0;
          first_q <= 1'b1;
        end
        RUN: begin
          first_q <= 1'b0;
          if (elem_fire) cnt <= cnt + 1'b1;
          if (!is_mac)   k   <= k + 1'b1;
        end
        DRAIN:   dcnt <= dcnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Operand latch: only observed outside IDLE, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && cmd_valid) begin
      op_q  <= uno_op_e'(cmd_op);
      len_q <= cmd_len;
      x_q   <= cmd_x;
      y_q   <= cmd_y;
      z_q   <= cmd_z;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          res_data <= '0;
    else if (capture) res_data <= pe_out;
  end

endmodule
